sprite_evaluator: RTL and testbench

- Per-scanline sprite evaluation stage, directly downstream of the render controller.
- Consumes the controller's spriteEval_EN, spriteEvalReset and lineCount strobes.
- Scans the 64 primary OAM entries, copies up to 8 in-range sprites into 32-byte secondary OAM, and reproduces the NES sprite-overflow search bug.
- Feeds the sprite fetch stage (secondary OAM contents, spriteCount, sprite0InLine) and the status register (overflow pulse).

---
 rtl/sprite_evaluator.sv | 192 +++++++++++++++++++
 tb/tb_sprite_evaluator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, copies up to SEC_SLOTS
// in-range sprites from primary OAM, then runs the NES-style overflow search.
module sprite_evaluator #(
  parameter int unsigned OAM_ENTRIES = 64,
  parameter int unsigned SEC_SLOTS   = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_N,
  input  logic                                 clock_EN,
  input  logic                                 spriteEval_EN,
  input  logic                                 spriteEvalReset,
  input  logic [8:0]                           lineCount,
  input  logic                                 spriteSize16,
  output logic [$clog2(OAM_ENTRIES)+1:0]       oamAddr,
  input  logic [7:0]                           oamData,
  output logic [$clog2(SEC_SLOTS)+1:0]         secOamAddr,
  output logic [7:0]                           secOamWData,
  output logic                                 secOamWE,
  output logic [$clog2(SEC_SLOTS+1)-1:0]       spriteCount,
  output logic                                 sprite0InLine,
  output logic                                 spriteOverflowSet
);

  localparam int unsigned NW         = $clog2(OAM_ENTRIES);
  localparam int unsigned SW         = $clog2(SEC_SLOTS);
  localparam int unsigned CW         = $clog2(SEC_SLOTS + 1);
  localparam int unsigned ECW        = 8;
  localparam int unsigned CLR_CYCLES = SEC_SLOTS * 8;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_EVAL_Y,
    ST_COPY,
    ST_OVF,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ECW-1:0]   eval_cyc_q, eval_cyc_d;
  logic [NW-1:0]    n_q, n_d;
  logic [1:0]       m_q, m_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [CW-1:0]    found_q, found_d;
  logic             s0_q, s0_d;
  logic             sec_we_q, sec_we_d;
  logic [SW+1:0]    sec_addr_q, sec_addr_d;
  logic [7:0]       sec_wdata_q, sec_wdata_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s0_line_q, s0_line_d;
  logic             ovf_q, ovf_d;

  logic [9:0]       diff;
  logic             in_range;
  logic             n_last;

  // Y range test; bit 9 of the widened difference is the borrow.
  always_comb begin
    diff     = {1'b0, lineCount} - {2'b00, oamData};
    in_range = !diff[9] && (diff[8:0] < (spriteSize16 ? 9'd16 : 9'd8));
  end

  assign n_last = (n_q == NW'(OAM_ENTRIES - 1));

  always_comb begin
    state_d     = state_q;
    eval_cyc_d  = eval_cyc_q;
    n_d         = n_q;
    m_d         = m_q;
    slot_d      = slot_q;
    found_d     = found_q;
    s0_d        = s0_q;
    sec_we_d    = 1'b0;
    sec_addr_d  = sec_addr_q;
    sec_wdata_d = sec_wdata_q;
    count_d     = count_q;
    s0_line_d   = s0_line_q;
    ovf_d       = 1'b0;

    if (spriteEvalReset) begin
      count_d    = found_q;
      s0_line_d  = s0_q;
      eval_cyc_d = '0;
      n_d        = '0;
      m_d        = '0;
      slot_d     = '0;
      found_d    = '0;
      s0_d       = 1'b0;
      state_d    = ST_CLEAR;
    end else if (spriteEval_EN) begin
      eval_cyc_d = eval_cyc_q + ECW'(1);
      // Even cycles present oamAddr; odd cycles consume oamData.
      case (state_q)
        ST_CLEAR: begin
          if (eval_cyc_q[0]) begin
            sec_we_d    = 1'b1;
            sec_addr_d  = eval_cyc_q[SW+2:1];
            sec_wdata_d = 8'hFF;
          end
          if (eval_cyc_q == ECW'(CLR_CYCLES - 1)) state_d = ST_EVAL_Y;
        end
        ST_EVAL_Y: begin
          if (eval_cyc_q[0]) begin
            sec_we_d    = 1'b1;
            sec_addr_d  = {slot_q, 2'b00};
            sec_wdata_d = oamData;
            if (in_range) begin
              found_d = found_q + CW'(1);
              s0_d    = s0_q | (n_q == '0);
              m_d     = 2'd1;
              state_d = ST_COPY;
            end else begin
              n_d = n_q + NW'(1);
              if (n_last) state_d = ST_DONE;
            end
          end
        end
        ST_COPY: begin
          if (eval_cyc_q[0]) begin
            sec_we_d    = 1'b1;
            sec_addr_d  = {slot_q, m_q};
            sec_wdata_d = oamData;
            if (m_q == 2'd3) begin
              m_d    = 2'd0;
              slot_d = slot_q + SW'(1);
              n_d    = n_q + NW'(1);
              if (n_last)                      state_d = ST_DONE;
              else if (found_q < CW'(SEC_SLOTS)) state_d = ST_EVAL_Y;
              else                             state_d = ST_OVF;
            end else begin
              m_d = m_q + 2'd1;
            end
          end
        end
        ST_OVF: begin
          // Byte offset advances alongside n, so non-Y bytes get tested as Y.
          if (eval_cyc_q[0]) begin
            if (in_range) begin
              ovf_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              n_d = n_q + NW'(1);
              m_d = m_q + 2'd1;
              if (n_last) state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= ST_CLEAR;
      eval_cyc_q  <= '0;
      n_q         <= '0;
      m_q         <= '0;
      slot_q      <= '0;
      found_q     <= '0;
      s0_q        <= 1'b0;
      sec_we_q    <= 1'b0;
      sec_addr_q  <= '0;
      sec_wdata_q <= '0;
      count_q     <= '0;
      s0_line_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clock_EN) begin
      state_q     <= state_d;
      eval_cyc_q  <= eval_cyc_d;
      n_q         <= n_d;
      m_q         <= m_d;
      slot_q      <= slot_d;
      found_q     <= found_d;
      s0_q        <= s0_d;
      sec_we_q    <= sec_we_d;
      sec_addr_q  <= sec_addr_d;
      sec_wdata_q <= sec_wdata_d;
      count_q     <= count_d;
      s0_line_q   <= s0_line_d;
      ovf_q       <= ovf_d;
    end
  end

  assign oamAddr           = {n_q, m_q};
  assign secOamAddr        = sec_addr_q;
  assign secOamWData       = sec_wdata_q;
  assign secOamWE          = sec_we_q;
  assign spriteCount       = count_q;
  assign sprite0InLine     = s0_line_q;
  assign spriteOverflowSet = ovf_q;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Scoreboard bench for sprite_evaluator: expected secondary-OAM writes are queued
// per line and popped by a monitor; line results are checked against hand values.
module tb_sprite_evaluator;

  logic       clock = 1'b0;
  logic       reset_N;
  logic       clock_EN;
  logic       spriteEval_EN;
  logic       spriteEvalReset;
  logic [8:0] lineCount;
  logic       spriteSize16;
  logic [7:0] oamAddr;
  logic [7:0] oamData;
  logic [4:0] secOamAddr;
  logic [7:0] secOamWData;
  logic       secOamWE;
  logic [3:0] spriteCount;
  logic       sprite0InLine;
  logic       spriteOverflowSet;

  sprite_evaluator dut (
    .clock             (clock),
    .reset_N           (reset_N),
    .clock_EN          (clock_EN),
    .spriteEval_EN     (spriteEval_EN),
    .spriteEvalReset   (spriteEvalReset),
    .lineCount         (lineCount),
    .spriteSize16      (spriteSize16),
    .oamAddr           (oamAddr),
    .oamData           (oamData),
    .secOamAddr        (secOamAddr),
    .secOamWData       (secOamWData),
    .secOamWE          (secOamWE),
    .spriteCount       (spriteCount),
    .sprite0InLine     (sprite0InLine),
    .spriteOverflowSet (spriteOverflowSet)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic [7:0] oam_mem [256];
  logic [7:0] sec_mem [32];
  wr_t        exp_q [$];
  wr_t        mon_e;
  int         total = 0;
  int         bad = 0;
  int         tb_cyc;
  int         ovf_seen = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Primary OAM: synchronous read, data valid the enabled cycle after the address.
  always @(posedge clock) begin
    if (clock_EN) oamData <= oam_mem[oamAddr];
  end

  // Window cycle counter (mirrors evalCycle numbering, counted from the bench side).
  always @(posedge clock or negedge reset_N) begin
    if (!reset_N) tb_cyc <= 0;
    else if (clock_EN) begin
      if (spriteEvalReset)    tb_cyc <= 0;
      else if (spriteEval_EN) tb_cyc <= tb_cyc + 1;
    end
  end

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_N && clock_EN) begin
      if (secOamWE) begin
        sec_mem[secOamAddr] = secOamWData;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write", secOamAddr, secOamWData);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", int'(secOamAddr), mon_e.addr);
          check("wr_data", int'(secOamWData), mon_e.data);
          if (mon_e.cyc >= 0) check("wr_cycle", tb_cyc, mon_e.cyc);
        end
      end
      if (spriteOverflowSet) ovf_seen++;
    end
  end

  function automatic bit in_rng(input int line, input int y, input bit s16);
    return (line >= y) && ((line - y) < (s16 ? 16 : 8));
  endfunction

  // Transaction-level reference of one line's secondary-OAM write stream.
  function automatic void build_exp(input int line, input bit s16);
    int slot = 0;
    int found = 0;
    int n = 0;
    int m = 0;
    exp_q.delete();
    for (int a = 0; a < 32; a++) exp_q.push_back('{a, 255, 2 * a + 2});
    while (n < 64 && found < 8) begin
      exp_q.push_back('{slot * 4, int'(oam_mem[n * 4]), -1});
      if (in_rng(line, int'(oam_mem[n * 4]), s16)) begin
        found++;
        for (int b = 1; b < 4; b++) exp_q.push_back('{slot * 4 + b, int'(oam_mem[n * 4 + b]), -1});
        slot++;
      end
      n++;
    end
  endfunction

  task automatic fill_default();
    for (int n = 0; n < 64; n++) begin
      oam_mem[n * 4]     = 8'hFF;
      oam_mem[n * 4 + 1] = 8'(n);
      oam_mem[n * 4 + 2] = 8'h00;
      oam_mem[n * 4 + 3] = 8'(8'h80 + n);
    end
  endtask

  task automatic do_line(input int line, input bit s16, input int freeze_at, input int rst_at);
    int n_done = 0;
    int fz = freeze_at;
    lineCount    = 9'(line);
    spriteSize16 = s16;
    build_exp(line, s16);
    ovf_seen      = 0;
    spriteEval_EN = 1'b1;
    while (n_done < 256) begin
      if (n_done == fz) begin
        spriteEval_EN = 1'b0;
        repeat (5) begin
          @(posedge clock);
          #1;
        end
        spriteEval_EN = 1'b1;
        fz = -1;
      end
      if (n_done == rst_at) begin
        #2;
        reset_N = 1'b0;
        #1;
        check("rst_secOamWE", int'(secOamWE), 0);
        check("rst_secOamAddr", int'(secOamAddr), 0);
        check("rst_secOamWData", int'(secOamWData), 0);
        check("rst_oamAddr", int'(oamAddr), 0);
        check("rst_spriteCount", int'(spriteCount), 0);
        check("rst_sprite0InLine", int'(sprite0InLine), 0);
        check("rst_overflow", int'(spriteOverflowSet), 0);
        exp_q.delete();
        spriteEval_EN = 1'b0;
        @(posedge clock);
        #1;
        reset_N = 1'b1;
        return;
      end
      @(posedge clock);
      #1;
      n_done++;
    end
    spriteEval_EN = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // End-of-line strobe, asserted together with the window to exercise priority.
  task automatic strobe();
    spriteEvalReset = 1'b1;
    spriteEval_EN   = 1'b1;
    @(posedge clock);
    #1;
    spriteEvalReset = 1'b0;
    spriteEval_EN   = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic base_oam();
    fill_default();
    oam_mem[0]  = 8'd10;
    oam_mem[20] = 8'd12;
  endtask

  initial begin
    reset_N         = 1'b0;
    clock_EN        = 1'b1;
    spriteEval_EN   = 1'b0;
    spriteEvalReset = 1'b0;
    lineCount       = '0;
    spriteSize16    = 1'b0;
    for (int i = 0; i < 32; i++) sec_mem[i] = 8'h00;
    fill_default();
    repeat (2) @(posedge clock);
    #1;
    check("reset_secOamWE", int'(secOamWE), 0);
    check("reset_secOamAddr", int'(secOamAddr), 0);
    check("reset_secOamWData", int'(secOamWData), 0);
    check("reset_oamAddr", int'(oamAddr), 0);
    check("reset_spriteCount", int'(spriteCount), 0);
    check("reset_sprite0InLine", int'(sprite0InLine), 0);
    check("reset_overflow", int'(spriteOverflowSet), 0);
    reset_N = 1'b1;
    @(posedge clock);
    #1;

    // Two sprites (0 and 5) on line 15, 8x8.
    base_oam();
    do_line(15, 1'b0, -1, -1);
    check("l15_ovf", ovf_seen, 0);
    strobe();
    check("l15_count", int'(spriteCount), 2);
    check("l15_s0", int'(sprite0InLine), 1);
    check("l15_sec0", int'(sec_mem[0]), 10);
    check("l15_sec1", int'(sec_mem[1]), 0);
    check("l15_sec3", int'(sec_mem[3]), 8'h80);
    check("l15_sec4", int'(sec_mem[4]), 12);
    check("l15_sec5", int'(sec_mem[5]), 5);
    check("l15_sec7", int'(sec_mem[7]), 8'h85);
    check("l15_sec8", int'(sec_mem[8]), 8'hFF);
    check("l15_sec9", int'(sec_mem[9]), 8'hFF);

    // Line 20: in range only as 8x16 (diffs 10 and 8).
    do_line(20, 1'b1, -1, -1);
    strobe();
    check("l20x16_count", int'(spriteCount), 2);
    check("l20x16_s0", int'(sprite0InLine), 1);
    check("l20x16_sec4", int'(sec_mem[4]), 12);
    do_line(20, 1'b0, -1, -1);
    strobe();
    check("l20x8_count", int'(spriteCount), 0);
    check("l20x8_s0", int'(sprite0InLine), 0);
    check("l20x8_sec0", int'(sec_mem[0]), 8'hFF);
    check("l20x8_sec1", int'(sec_mem[1]), 8'hFF);

    // Nine sprites at Y=30: ninth triggers a true overflow, never written.
    fill_default();
    for (int n = 0; n < 9; n++) oam_mem[n * 4] = 8'd30;
    do_line(32, 1'b0, -1, -1);
    check("nine_ovf", ovf_seen, 1);
    strobe();
    check("nine_count", int'(spriteCount), 8);
    check("nine_s0", int'(sprite0InLine), 1);
    check("nine_sec28", int'(sec_mem[28]), 30);
    check("nine_sec29", int'(sec_mem[29]), 7);
    check("nine_sec31", int'(sec_mem[31]), 8'h87);

    // Only eight real hits; the diagonal search mistakes entry 9's tile byte for Y.
    fill_default();
    for (int n = 0; n < 8; n++) oam_mem[n * 4] = 8'd30;
    oam_mem[37] = 8'd32;
    do_line(32, 1'b0, -1, -1);
    check("bug_ovf", ovf_seen, 1);
    strobe();
    check("bug_count", int'(spriteCount), 8);

    // Window paused for 5 cycles mid-evaluation gives the same result.
    base_oam();
    do_line(15, 1'b0, 100, -1);
    check("frz_ovf", ovf_seen, 0);
    strobe();
    check("frz_count", int'(spriteCount), 2);
    check("frz_s0", int'(sprite0InLine), 1);
    check("frz_sec0", int'(sec_mem[0]), 10);
    check("frz_sec5", int'(sec_mem[5]), 5);
    check("frz_sec7", int'(sec_mem[7]), 8'h85);

    // Asynchronous reset while copying sprite 0, then a clean line afterwards.
    do_line(15, 1'b0, -1, 68);
    base_oam();
    do_line(15, 1'b0, -1, -1);
    strobe();
    check("post_rst_count", int'(spriteCount), 2);
    check("post_rst_s0", int'(sprite0InLine), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
